// File: rtl/hcsr04_pkg.sv
// Shared HC-SR04 definitions used by the echo emulator and the ranging driver.
// Holds the emulator state encoding, the default timing constants and the echo
// width rule applied when a trigger is accepted.
package hcsr04_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG_HI = 3'd1,
        ST_DELAY   = 3'd2,
        ST_ECHO    = 3'd3,
        ST_HOLDOFF = 3'd4
    } emu_state_e;

    localparam int unsigned DEF_TRIG_CYCLES    = 32'd10;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd25000;
    localparam int unsigned DEF_PERIOD_CYCLES  = 32'd50000;

    // Echo width: forced long in no-target mode, otherwise tof clamped to [1, max_w].
    function automatic int unsigned echo_width(
        input logic        no_target,
        input int unsigned tof,
        input int unsigned max_w,
        input int unsigned no_echo_w
    );
        int unsigned w;
        if (no_target) begin
            w = no_echo_w;
        end else if (tof == 32'd0) begin
            w = 32'd1;
        end else if (tof > max_w) begin
            w = max_w;
        end else begin
            w = tof;
        end
        return w;
    endfunction

endpackage

// File: rtl/hcsr04_sync2.sv
// Two-flop synchronizer with active-low synchronous reset. Brings the
// asynchronous trig pin into the clk domain; also reusable for echo on the
// driver side.
module hcsr04_sync2
    import hcsr04_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Shift the raw input through two flops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 responder model: validates the trig pulse, waits a fixed latency and
// drives an echo pulse of the programmed width, then holds off before re-arming.
// Optional build macro HCSR04_EMU_TRIGW_CHECK_EN enables the minimum trigger
// width check and the trig_err pulse; without it any trig high pulse is accepted.
module hcsr04_echo_emulator
    import hcsr04_pkg::*;
#(
    parameter int unsigned MIN_TRIG_CYCLES = DEF_TRIG_CYCLES,
    parameter int unsigned LATENCY_CYCLES  = 32'd20,
    parameter int unsigned MAX_ECHO_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned NO_ECHO_CYCLES  = 32'd30000,
    parameter int unsigned HOLDOFF_CYCLES  = 32'd100,
    parameter int unsigned ECHO_W          = $clog2(NO_ECHO_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              trig_i,
    input  logic [ECHO_W-1:0] tof_i,
    input  logic              no_target_i,
    output logic              echo_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              trig_err_o
);

    // Elaboration-time parameter sanity checks.
    if (LATENCY_CYCLES < 32'd1) begin : g_bad_latency
        $error("LATENCY_CYCLES must be at least 1");
    end
    if (NO_ECHO_CYCLES <= MAX_ECHO_CYCLES) begin : g_bad_no_echo
        $error("NO_ECHO_CYCLES must exceed MAX_ECHO_CYCLES");
    end
    if ((MIN_TRIG_CYCLES < 32'd1) || (HOLDOFF_CYCLES < 32'd1)) begin : g_bad_counts
        $error("MIN_TRIG_CYCLES and HOLDOFF_CYCLES must be at least 1");
    end

    localparam logic [ECHO_W-1:0] LAT_LAST  = ECHO_W'(LATENCY_CYCLES - 32'd1);
    localparam logic [ECHO_W-1:0] HOLD_LAST = ECHO_W'(HOLDOFF_CYCLES - 32'd1);

    logic              trig_s;
    logic [ECHO_W-1:0] width_s;
    emu_state_e        state_q, state_d;
    logic [ECHO_W-1:0] cnt_q, cnt_d;
    logic [ECHO_W-1:0] w_q, w_d;
    logic              armed_q, armed_d;
    logic              echo_q, echo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

`ifdef HCSR04_EMU_TRIGW_CHECK_EN
    localparam logic [ECHO_W-1:0] MIN_C = ECHO_W'(MIN_TRIG_CYCLES);
    logic trig_err_q, trig_err_d;
`endif

    hcsr04_sync2 u_trig_sync (
        .clk (clk),
        .rst (rst),
        .d_i (trig_i),
        .q_o (trig_s)
    );

    // Width that would be latched if the trigger were accepted this cycle.
    assign width_s = ECHO_W'(echo_width(no_target_i, 32'(tof_i),
                                        MAX_ECHO_CYCLES, NO_ECHO_CYCLES));

    // Next-state, counter and output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_d      = w_q;
        armed_d  = 1'b0;
        done_d   = 1'b0;
`ifdef HCSR04_EMU_TRIGW_CHECK_EN
        trig_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // A trig_s low must be seen in IDLE before a high is taken as a new trigger.
                armed_d = armed_q | ~trig_s;
                if (en_i && trig_s && armed_q) begin
                    state_d = ST_TRIG_HI;
                    cnt_d   = ECHO_W'(1);
                    armed_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRIG_HI: begin
`ifdef HCSR04_EMU_TRIGW_CHECK_EN
                if (trig_s) begin
                    if (cnt_q < MIN_C) begin
                        cnt_d = cnt_q + ECHO_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else if (cnt_q < MIN_C) begin
                    trig_err_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_IDLE;
                end else begin
                    w_d     = width_s;
                    cnt_d   = '0;
                    state_d = ST_DELAY;
                end
`else
                if (trig_s) begin
                    state_d = ST_TRIG_HI;
                end else begin
                    w_d     = width_s;
                    cnt_d   = '0;
                    state_d = ST_DELAY;
                end
`endif
            end
            ST_DELAY: begin
                if (cnt_q == LAT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_ECHO;
                end else begin
                    cnt_d = cnt_q + ECHO_W'(1);
                end
            end
            ST_ECHO: begin
                if (cnt_q == (w_q - ECHO_W'(1))) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_HOLDOFF;
                end else begin
                    cnt_d = cnt_q + ECHO_W'(1);
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + ECHO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                w_d     = '0;
            end
        endcase
        echo_d = (state_d == ST_ECHO);
        busy_d = (state_d == ST_DELAY) || (state_d == ST_ECHO) || (state_d == ST_HOLDOFF);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            armed_q <= 1'b0;
            echo_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            armed_q <= armed_d;
            echo_q  <= echo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef HCSR04_EMU_TRIGW_CHECK_EN
    // Short-trigger error pulse register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            trig_err_q <= 1'b0;
        end else begin
            trig_err_q <= trig_err_d;
        end
    end
    assign trig_err_o = trig_err_q;
`else
    assign trig_err_o = 1'b0;
`endif

    assign echo_o = echo_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// Directed bench for hcsr04_echo_emulator with default parameters.
// Edge numbering: edge 1 is the first clock edge at which trig is driven high;
// outputs are sampled on the falling edge after each numbered edge.
module tb_hcsr04_echo_emulator;
    import hcsr04_pkg::*;

    localparam int TOF_W = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en_i = 1'b1;
    logic             trig_i = 1'b0;
    logic [TOF_W-1:0] tof_i = '0;
    logic             no_target_i = 1'b0;
    logic             echo_o, busy_o, done_o, trig_err_o;

    hcsr04_echo_emulator dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .trig_i      (trig_i),
        .tof_i       (tof_i),
        .no_target_i (no_target_i),
        .echo_o      (echo_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .trig_err_o  (trig_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   trig_len;
        int   tof;
        logic nt;
        int   busy_rise;
        int   echo_rise;
        int   echo_len;
        int   done_e;
        int   busy_fall;
        int   err_cnt;
    } vec_t;

    vec_t vecs[6];
    int n_vec = 0;
    int n_bad = 0;

    int e, busy_rise_e, busy_fall_e, echo_rise_e, last_rise_e, rises;
    int echo_high, done_e, done_cnt, err_cnt;
    logic prev_busy, prev_echo;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_stats();
        e = 0; busy_rise_e = 0; busy_fall_e = 0; echo_rise_e = 0; last_rise_e = 0;
        rises = 0; echo_high = 0; done_e = 0; done_cnt = 0; err_cnt = 0;
        prev_busy = 1'b0; prev_echo = 1'b0;
    endtask

    // Drive trig for the next edge, then sample outputs on the falling edge.
    task automatic tick(input logic trig_v);
        trig_i = trig_v;
        @(posedge clk);
        e++;
        @(negedge clk);
        if (busy_o && !prev_busy && busy_rise_e == 0) busy_rise_e = e;
        if (!busy_o && prev_busy && busy_fall_e == 0) busy_fall_e = e;
        if (echo_o && !prev_echo) begin
            rises++;
            if (echo_rise_e == 0) echo_rise_e = e;
            last_rise_e = e;
        end
        if (echo_o) echo_high++;
        if (done_o) begin
            done_cnt++;
            if (done_e == 0) done_e = e;
        end
        if (trig_err_o) err_cnt++;
        prev_busy = busy_o;
        prev_echo = echo_o;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int budget;
        reset_stats();
        tof_i = TOF_W'(v.tof);
        no_target_i = v.nt;
        budget = v.trig_len + 200 + v.echo_len;
        for (int k = 1; k <= budget; k++) begin
            // Inputs change after acceptance; the latched width must not follow.
            if (k == v.trig_len + 10) begin
                tof_i = TOF_W'(3);
                no_target_i = 1'b0;
            end
            tick(k <= v.trig_len);
        end
        chk({tag, "_busy_rise"}, busy_rise_e, v.busy_rise);
        chk({tag, "_echo_rise"}, echo_rise_e, v.echo_rise);
        chk({tag, "_echo_len"},  echo_high,   v.echo_len);
        chk({tag, "_echo_cnt"},  rises,       (v.echo_len > 0) ? 1 : 0);
        chk({tag, "_done_edge"}, done_e,      v.done_e);
        chk({tag, "_done_cnt"},  done_cnt,    (v.echo_len > 0) ? 1 : 0);
        chk({tag, "_busy_fall"}, busy_fall_e, v.busy_fall);
        chk({tag, "_trig_err"},  err_cnt,     v.err_cnt);
        if (v.nt) begin
            chk({tag, "_exceeds_timeout"}, int'(echo_high > int'(DEF_TIMEOUT_CYCLES)), 1);
        end
    endtask

    initial begin
        vec_t after_rst;
        // trig_len, tof, nt, busy_rise, echo_rise, echo_len, done_e, busy_fall, err
        vecs[0] = '{12, 1000,  1'b0, 15, 35, 1000,  1035,  1135,  0};
`ifdef HCSR04_EMU_TRIGW_CHECK_EN
        vecs[1] = '{5,  300,   1'b0, 0,  0,  0,     0,     0,     1};
        vecs[5] = '{9,  20,    1'b0, 0,  0,  0,     0,     0,     1};
`else
        vecs[1] = '{5,  300,   1'b0, 8,  28, 300,   328,   428,   0};
        vecs[5] = '{9,  20,    1'b0, 12, 32, 20,    52,    152,   0};
`endif
        vecs[2] = '{10, 0,     1'b0, 13, 33, 1,     34,    134,   0};
        vecs[3] = '{10, 32767, 1'b0, 13, 33, 25000, 25033, 25133, 0};
        vecs[4] = '{10, 50,    1'b1, 13, 33, 30000, 30033, 30133, 0};
        after_rst = '{10, 50,  1'b0, 13, 33, 50,    83,    183,   0};

        // Reset state.
        reset_stats();
        tick(1'b0);
        tick(1'b0);
        chk("rst_echo", int'(echo_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_trig_err", int'(trig_err_o), 0);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) tick(1'b0);

        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Extra triggers during ECHO and HOLDOFF are ignored; one after HOLDOFF is served.
        reset_stats();
        tof_i = TOF_W'(200);
        no_target_i = 1'b0;
        for (int k = 1; k <= 800; k++) begin
            tick((k <= 12) || (k >= 100 && k <= 111) || (k >= 250 && k <= 261) ||
                 (k >= 400 && k <= 411));
        end
        chk("retrig_echo_cnt", rises, 2);
        chk("retrig_first_rise", echo_rise_e, 35);
        chk("retrig_second_rise", last_rise_e, 434);
        chk("retrig_echo_len", echo_high, 400);
        chk("retrig_done_cnt", done_cnt, 2);

        // trig still high when HOLDOFF ends is not a new trigger.
        reset_stats();
        tof_i = TOF_W'(5);
        for (int k = 1; k <= 400; k++) begin
            tick((k <= 12) || (k >= 100 && k <= 300));
        end
        chk("held_echo_cnt", rises, 1);
        chk("held_busy_fall", busy_fall_e, 140);

        // Disarmed: no trigger accepted while en is low.
        reset_stats();
        en_i = 1'b0;
        for (int k = 1; k <= 100; k++) tick(k <= 12);
        chk("en_low_echo_cnt", rises, 0);
        chk("en_low_busy_rise", busy_rise_e, 0);
        en_i = 1'b1;

        // Reset mid-echo, then a normal response afterwards.
        reset_stats();
        tof_i = TOF_W'(1000);
        for (int k = 1; k <= 100; k++) tick(k <= 12);
        chk("pre_rst_echo", int'(echo_o), 1);
        rst = 1'b0;
        tick(1'b0);
        chk("mid_rst_echo", int'(echo_o), 0);
        chk("mid_rst_busy", int'(busy_o), 0);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) tick(1'b0);
        chk("post_rst_done_cnt", done_cnt, 0);
        run_vec("after_rst", after_rst);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
